// File: rtl/fpu_wb_queue.sv
// fpu_wb_queue: in-order FIFO of {tag, 32-bit result} between the FPU converters and the float register-file write port.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_tag producer side;
// out_valid/out_ready/out_data/out_tag register-file side; flush drops all entries; count is occupancy 0..DEPTH.
// Optional macro FPU_WB_FTZ_EN: denormal inputs are stored as signed zero.
module fpu_wb_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [TAG_W+31:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       wdata;
  logic              push, pop;
`ifdef FPU_WB_FTZ_EN
  assign wdata = (in_data[30:23] == 8'h00 && |in_data[22:0]) ? {in_data[31], 31'b0} : in_data;
`else
  assign wdata = in_data;
`endif
  assign in_ready  = cnt_q != CNT_W'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt_q;
  // empty queue presents zeros rather than stale storage
  assign {out_tag, out_data} = out_valid ? mem_q[rd_q] : '0;
  always_ff @(posedge clk)
    if (push && !flush && !rst) mem_q[wr_q] <= {in_tag, wdata};
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule
